// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle RV32I controller: opcodes, FSM states and
// datapath select/control encodings.
package multicycle_controller_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNC3_W  = 3;
  localparam int unsigned FUNC7_W  = 7;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned IMM_W    = 3;
  localparam int unsigned ALU_W    = 3;

  localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BR   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_HALT
  } state_t;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;
  localparam logic [SEL_W-1:0] RES_IMM    = 2'b11;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_A     = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  localparam logic [SEL_W-1:0] ADR_PC     = 2'b00;
  localparam logic [SEL_W-1:0] ADR_RESULT = 2'b01;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation decode from func3/func7; SUB only for R-type.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC3_W-1:0]  func3,
  input  logic [FUNC7_W-1:0]  func7,
  output logic [ALU_W-1:0]    alu_control_c
);

  // Only func7[5] distinguishes operations among the supported set.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_comb begin
    alu_control_c = ALU_ADD;
    case (func3)
      3'b000: if (opcode == OP_R && func7[5]) alu_control_c = ALU_SUB;
      3'b010: alu_control_c = ALU_SLT;
      3'b100: alu_control_c = ALU_XOR;
      3'b110: alu_control_c = ALU_OR;
      3'b111: alu_control_c = ALU_AND;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath.
// Build option ILLEGAL_INSTR_EN: unsupported opcodes halt and raise 'illegal'.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC3_W-1:0]  func3,
  input  logic [FUNC7_W-1:0]  func7,
  input  logic                zero,
  input  logic                negative,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [SEL_W-1:0]    AdrSrc,
  output logic [SEL_W-1:0]    ALUSrcA,
  output logic [SEL_W-1:0]    ALUSrcB,
  output logic [SEL_W-1:0]    ResultSrc,
  output logic [IMM_W-1:0]    ImmSrc,
  output logic [ALU_W-1:0]    ALUControl
`ifdef ILLEGAL_INSTR_EN
  ,
  output logic                illegal
`endif
);

  state_t state_q, state_d;
  logic [ALU_W-1:0] alu_dec_c;

  multicycle_controller_alu_decoder u_alu_decoder (
    .opcode        (opcode),
    .func3         (func3),
    .func7         (func7),
    .alu_control_c (alu_dec_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = ADR_PC;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
`ifdef ILLEGAL_INSTR_EN
    illegal    = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <= branch/jal target; ALUOut still holds PC+4 for the link write.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (opcode == OP_BR)       ImmSrc = IMM_B;
        else if (opcode == OP_JAL) ImmSrc = IMM_J;
        if (opcode == OP_JAL || opcode == OP_JALR) RegWrite = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
          OP_LUI:       state_d = S_LUI;
`ifdef ILLEGAL_INSTR_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
        state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = ADR_RESULT;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MDR;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = ADR_RESULT;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUControl = alu_dec_c;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dec_c;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        // PCWrite is the only Mealy output: it follows the live ALU flags.
        ALUSrcA    = SRCA_A;
        ALUControl = ALU_SUB;
        case (func3)
          3'b000:  PCWrite = zero;
          3'b001:  PCWrite = ~zero;
          3'b100:  PCWrite = negative;
          3'b101:  PCWrite = ~negative;
          default: PCWrite = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JAL: begin
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
        state_d   = S_FETCH;
      end
      S_LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = RES_IMM;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
`ifdef ILLEGAL_INSTR_EN
        illegal = 1'b1;
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // No architectural write may happen while reset is held.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM driving the multicycle RV32I datapath.
- Consumes opcode/func3/func7/zero/negative from the datapath.
- Produces every enable and select the datapath takes, one state per cycle.
- Supported ops: add/sub/and/or/xor/slt, addi/ori/xori/slti/andi, lw, sw, beq/bne/blt/bge, jal, jalr, lui.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instruction[6:0]
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]
- zero  in  1  ALU result == 0
- negative  in  1  ALU result[31]
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables
- AdrSrc  out  2  00 PC, 01 result
- ALUSrcA  out  2  00 PC, 01 Old_PC, 10 A
- ALUSrcB  out  2  00 B, 01 imm, 10 const 4
- ResultSrc  out  2  00 ALUOut, 01 MDR, 10 ALU_result, 11 imm
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT

Behaviour:
- One clk, synchronous active-high rst; state register only.
- rst high: next state FETCH; all four write enables forced 0 during the rst cycle.
- Defaults in every state: enables 0, selects 00, ALUControl ADD, ImmSrc I.
- All outputs are Moore, except PCWrite in BRANCH.
- FETCH: AdrSrc=00, IRWrite=1, SrcA=00, SrcB=10, ADD, ResultSrc=10, PCWrite=1 -> DECODE.
- DECODE: SrcA=01 (fetch address), SrcB=01, ADD (ALUOut <= target). ImmSrc=B for branch, J for jal, else I.
  - jal/jalr: RegWrite=1, ResultSrc=00, so rd <= fetch PC+4 still held in ALUOut.
  - rd==rs1 on jalr is safe: A latches the pre-write value.
  - Next state: lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; branch -> BRANCH; jal -> JAL; jalr -> JALR; lui -> LUI; other -> FETCH (nop).
- MEMADR: SrcA=10, SrcB=01, ImmSrc S for sw / I for lw, ADD -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=01, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=01, ResultSrc=00, MemWrite=1 -> FETCH.
- EXECR: SrcA=10, SrcB=00, ALU decode -> ALUWB.
- EXECI: SrcA=10, SrcB=01, ALU decode -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- ALU decode by func3:
  - 000: ADD; SUB only when R-type and func7[5]=1.
  - 010: SLT. 100: XOR. 110: OR. 111: AND.
  - Others: ADD.
- BRANCH: SrcA=10, SrcB=00, SUB, ResultSrc=00 -> FETCH.
  - PCWrite = beq:zero, bne:~zero, blt:negative, bge:~negative.
  - Other func3: PCWrite=0.
  - Signed overflow ignored.
- JAL: ResultSrc=00, PCWrite=1 -> FETCH.
- JALR: SrcA=10, SrcB=01, ImmSrc I, ADD, ResultSrc=10, PCWrite=1 -> FETCH. Target LSB not cleared.
- LUI: ImmSrc=U, ResultSrc=11, RegWrite=1 -> FETCH.
- CPI: lw 5, sw/R/I 4, branch/jal/jalr/lui 3.

Optional Feature:
- Macro ILLEGAL_INSTR_EN.
- Defined:
  - Adds output port illegal (1 bit).
  - Unsupported opcode in DECODE -> HALT.
  - HALT: all enables 0, illegal=1, exits only via rst.
- Undefined: no port; unsupported opcode -> FETCH as nop.

Decomposition:
- Shared package holds:
  - opcode constants (R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111);
  - state enum;
  - ALUControl, ImmSrc, ResultSrc and SrcA/SrcB encodings.
- One sub-module: alu_decoder (opcode, func3, func7 -> ALUControl), purely combinational.

Test Plan:
- Reset:
  - rst=1 for 2 cycles -> all enables 0.
  - First cycle after release is FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10.
- R-type:
  - opcode 0110011, func3 000, func7 0100000 -> FETCH, DECODE, EXECR with ALUControl=001, then ALUWB with RegWrite=1, ResultSrc=00.
  - 4 cycles total.
- lw:
  - opcode 0000011 -> MEMADR(ImmSrc 000), MEMREAD(AdrSrc 01), MEMWB(ResultSrc 01, RegWrite 1).
  - Next FETCH at cycle 6.
- bne:
  - func3 001 with zero=1 -> PCWrite=0 in BRANCH.
  - Repeat with zero=0 -> PCWrite=1, ResultSrc=00.
- jal:
  - DECODE shows RegWrite=1, ImmSrc=011, ALUSrcA=01.
  - JAL shows PCWrite=1, ResultSrc=00.
- Illegal/edge:
  - opcode 1111111 -> returns to FETCH (macro off), or HALT with illegal=1 until rst (macro on).
  - rst asserted in MEMREAD -> FETCH next cycle, MemWrite/RegWrite never pulse.
